mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_cond_neg.sv | 20 ++
 rtl/mult_div_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_pkg
// Desc    : Shared types and constants for the HI/LO multiply/divide unit.
// Rev     : 1.0  initial release
// ============================================================================
package mdu_pkg;

   localparam int C_DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   function automatic logic op_is_div(input mdu_op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input mdu_op_t op);
      return ~op[0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_cond_neg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_cond_neg
// Desc    : Conditional two's-complement negation (magnitude / sign restore).
// Rev     : 1.0  initial release
// ============================================================================
module mdu_cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

   assign dout = neg ? (~din + C_ONE) : din;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mult_div_unit
// Desc    : Iterative HI/LO multiply/divide unit, one radix-2 step per cycle.
//           Option MDU_DIVZERO_TRAP_EN: divide-by-zero pulses div_zero and
//           leaves HI/LO untouched.
// Rev     : 1.0  initial release
// ============================================================================
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = C_DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_t       r_state;
   mdu_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_div;
   logic             r_neg_lo;
   logic             r_neg_hi;
   logic             r_done;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_accept;
   logic             w_fix_wr;
   logic             w_res_wr;
   mdu_op_t          w_op;
   logic             w_is_div;
   logic             w_sa;
   logic             w_sb;
   logic             w_b_zero;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;

   assign w_op     = mdu_op_t'(op);
   assign w_is_div = op_is_div(w_op);
   assign w_sa     = op_is_signed(w_op) & a[WIDTH-1];
   assign w_sb     = op_is_signed(w_op) & b[WIDTH-1];
   assign w_b_zero = (b == '0);

   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_a (.neg(w_sa), .din(a), .dout(w_mag_a));
   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_b (.neg(w_sb), .din(b), .dout(w_mag_b));

   // Multiply: acc grows by the multiplicand, {acc,q} shifts right each step.
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH:0]   w_sum;
   assign w_addend = r_q[0] ? r_m : '0;
   assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

   // Divide: restoring step on the remainder shifted left by one dividend bit.
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;
   assign w_shift = {r_acc, r_q[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_m});
   assign w_diff  = w_shift[WIDTH-1:0] - r_m;

   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   mdu_cond_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
      .neg (r_neg_lo),
      .din ({r_acc, r_q}),
      .dout(w_prod_fix)
   );
   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (.neg(r_neg_lo), .din(r_q),   .dout(w_quo_fix));
   mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_rem (.neg(r_neg_hi), .din(r_acc), .dout(w_rem_fix));

   assign {w_res_hi, w_res_lo} = r_is_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fix_wr    = 1'b0;
      busy        = 1'b1;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start && !abort) begin
               w_state_nxt = CALC;
               w_accept    = 1'b1;
            end
         end
         CALC: begin
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = FIX;
            end
         end
         FIX: begin
            w_state_nxt = IDLE;
            w_fix_wr    = !abort;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_acc    <= '0;
         r_q      <= '0;
         r_m      <= '0;
      end else if (w_accept) begin
         r_cnt    <= CNT_W'(WIDTH - 1);
         r_is_div <= w_is_div;
         r_acc    <= '0;
         if (w_is_div && w_b_zero) begin
            // Raw dividend with zero divisor leaves hi=a, lo=all ones.
            r_q      <= a;
            r_m      <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
         end else begin
            r_q      <= w_is_div ? w_mag_a : w_mag_b;
            r_m      <= w_is_div ? w_mag_b : w_mag_a;
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa;
         end
      end else if (r_state == CALC) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (r_is_div) begin
            r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
         end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
         end
      end
   end

`ifdef MDU_DIVZERO_TRAP_EN
   logic r_dz;
   logic r_div_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dz       <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         if (w_accept) begin
            r_dz <= w_is_div & w_b_zero;
         end
         r_div_zero <= w_fix_wr & r_dz;
      end
   end

   assign w_res_wr = w_fix_wr & ~r_dz;
   assign div_zero = r_div_zero;
`else
   assign w_res_wr = w_fix_wr;
   assign div_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_fix_wr;
         if (w_res_wr) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (r_state == IDLE) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
         end
      end
   end

   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_div_unit
// Desc    : Self-checking bench for mult_div_unit (WIDTH=32), directed table,
//           corner sequences and random ops against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .abort   (abort),
      .op      (op),
      .a       (a),
      .b       (b),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .div_zero(div_zero),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vec [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the architectural rules.
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] old_hi, input logic [31:0] old_lo,
                                 output logic [31:0] eh, output logic [31:0] el, output logic edz);
      longint      sp;
      logic [63:0] up;
      int          sx;
      int          sy;
      edz = 1'b0;
      eh  = old_hi;
      el  = old_lo;
      sx  = $signed(x);
      sy  = $signed(y);
      case (o)
         2'b00: begin
            sp = longint'(sx) * longint'(sy);
            {eh, el} = sp;
         end
         2'b01: begin
            up = {32'b0, x} * {32'b0, y};
            {eh, el} = up;
         end
         default: begin
            if (y == 32'd0) begin
`ifdef MDU_DIVZERO_TRAP_EN
               edz = 1'b1;
`else
               eh = x;
               el = 32'hFFFFFFFF;
`endif
            end else if (o == 2'b11) begin
               el = x / y;
               eh = x % y;
            end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               el = 32'h80000000;
               eh = 32'd0;
            end else begin
               el = sx / sy;
               eh = sx % sy;
            end
         end
      endcase
   endfunction

   // Waits (bounded) for done; lat counts posedges since acceptance.
   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic dz, output logic [31:0] rh, output logic [31:0] rl);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      wait_done(0, lat);
      dz = div_zero;
      rh = hi;
      rl = lo;
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
   endtask

   task automatic write_hilo(input logic [31:0] vh, input logic [31:0] vl);
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = vh;
      lo_we = 1'b0;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b1; wdata = vl;
      @(negedge clk);
      lo_we = 1'b0;
      m_hi = vh;
      m_lo = vl;
   endtask

   initial begin
      int          lat;
      int          saw;
      logic        dz;
      logic        edz;
      logic [31:0] rh;
      logic [31:0] rl;
      logic [31:0] eh;
      logic [31:0] el;
      logic [1:0]  o;
      logic [31:0] x;
      logic [31:0] y;

      vec[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vec[1] = '{2'b01, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB};
      vec[2] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
      vec[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vec[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      vec[5] = '{2'b11, 32'd9,        32'd3,        32'd0,        32'd3};
      vec[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
      vec[7] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vec[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      chk("reset_hi",       64'(hi),       64'd0);
      chk("reset_lo",       64'(lo),       64'd0);
      chk("reset_busy",     64'(busy),     64'd0);
      chk("reset_done",     64'(done),     64'd0);
      chk("reset_div_zero", 64'(div_zero), 64'd0);
      rst_n = 1'b1;
      m_hi = '0;
      m_lo = '0;

      // MTHI in IDLE lands on the next edge.
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_idle", 64'(hi), 64'h1234);
      m_hi = 32'h1234;

      for (int i = 0; i < 9; i++) begin
         run_op(vec[i].op, vec[i].a, vec[i].b, lat, dz, rh, rl);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
         chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(vec[i].hi));
         chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(vec[i].lo));
         chk($sformatf("vec%0d_div_zero", i), 64'(dz), 64'd0);
         m_hi = vec[i].hi;
         m_lo = vec[i].lo;
      end

      // Divide by zero.
      write_hilo(32'h0000AAAA, 32'h00005555);
      model(2'b11, 32'd5, 32'd0, m_hi, m_lo, eh, el, edz);
      run_op(2'b11, 32'd5, 32'd0, lat, dz, rh, rl);
      chk("divz_latency",  64'(lat), 64'd33);
      chk("divz_flag",     64'(dz),  64'(edz));
      chk("divz_hi",       64'(rh),  64'(eh));
      chk("divz_lo",       64'(rl),  64'(el));
      m_hi = eh;
      m_lo = el;

      // Abort at cycle 10 of a MULT, with a stray start pulse while busy.
      write_hilo(32'h0BADF00D, 32'h0C0FFEE0);
      @(negedge clk);
      op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      op = 2'b01; a = 32'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      saw = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw++;
      end
      chk("abort_no_done", 64'(saw), 64'd0);
      chk("abort_hi", 64'(hi), 64'(m_hi));
      chk("abort_lo", 64'(lo), 64'(m_lo));

      // Abort together with start in IDLE: nothing accepted.
      @(negedge clk);
      op = 2'b11; a = 32'd50; b = 32'd5; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_idle_busy", 64'(busy), 64'd0);

      // Start pulse mid-op is ignored; result and latency belong to the first op.
      @(negedge clk);
      op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      op = 2'b00; a = 32'hFFFFFFFF; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(5, lat);
      chk("ignore_start_latency", 64'(lat), 64'd33);
      chk("ignore_start_hi", 64'(hi), 64'd2);
      chk("ignore_start_lo", 64'(lo), 64'd14);
      @(negedge clk);
      chk("ignore_start_idle", 64'(busy), 64'd0);
      m_hi = 32'd2;
      m_lo = 32'd14;

      // MTHI during busy is dropped.
      @(negedge clk);
      op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      hi_we = 1'b1; wdata = 32'hDEAD0000;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_busy_hi", 64'(hi), 64'(m_hi));
      wait_done(4, lat);
      chk("mthi_busy_result_hi", 64'(hi), 64'd0);
      chk("mthi_busy_result_lo", 64'(lo), 64'd6);
      m_hi = 32'd0;
      m_lo = 32'd6;

      // Same-cycle MTLO and start: write lands first, result overwrites later.
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h0000ABCD;
      op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1;
      @(negedge clk);
      lo_we = 1'b0; start = 1'b0;
      chk("mtlo_start_lo", 64'(lo), 64'h0000ABCD);
      wait_done(0, lat);
      chk("mtlo_start_latency", 64'(lat), 64'd33);
      chk("mtlo_start_result_lo", 64'(lo), 64'd3);
      m_hi = 32'd0;
      m_lo = 32'd3;

      // Asynchronous reset at cycle 15 of a DIV.
      write_hilo(32'h00000077, 32'h00000088);
      @(negedge clk);
      op = 2'b10; a = 32'h00001000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_hi",   64'(hi),   64'd0);
      chk("async_rst_lo",   64'(lo),   64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_hi = '0;
      m_lo = '0;
      run_op(2'b11, 32'd9, 32'd3, lat, dz, rh, rl);
      chk("post_rst_hi", 64'(rh), 64'd0);
      chk("post_rst_lo", 64'(rl), 64'd3);

      // Random operations against the reference model.
      for (int i = 0; i < 120; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'hFFFFFFFF;
            1: x = 32'h80000000;
            2: y = 32'($urandom_range(1, 15));
            3: x = 32'($urandom_range(0, 255));
            default: ;
         endcase
         if (y == 32'd0) y = 32'd1;
         model(o, x, y, m_hi, m_lo, eh, el, edz);
         run_op(o, x, y, lat, dz, rh, rl);
         chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
         chk($sformatf("rand%0d_op%0d_%h_%h", i, o, x, y), {rh, rl}, {eh, el});
         m_hi = eh;
         m_lo = el;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
